xout_accum: RTL and testbench
=============================

# xout_accum

Downstream stage for the iterative multiply-subtract entity. It accepts its 8-bit `XOUT` result stream over a valid/ready handshake. It accumulates a window of `NSAMPLES` results into a sum, tracks the window maximum, and presents both on a registered output that is held until the consumer takes it. A `FLUSH` input closes a partial window early.

## Interface
Parameters:
- `DATA_W`, 8: width of the incoming `XOUT` samples.
- `NSAMPLES`, 4: samples per window; legal range 1..255.
- `SUM_W`, 16: width of the `SUM` output; must be at least `DATA_W`.

Ports:
- `CLK` in 1: single clock; all state changes on its rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `XOUT` in `DATA_W`: sample from the upstream entity, unsigned.
- `IN_VALID` in 1: `XOUT` is valid.
- `IN_READY` out 1: block accepts a sample this cycle.
- `FLUSH` in 1: close the current window after this cycle's accepted sample, if any.
- `SUM` out `SUM_W`: window sum, registered.
- `MAXV` out `DATA_W`: largest sample in the window, registered.
- `NCNT` out 8: number of samples in the emitted window.
- `OUT_VALID` out 1: `SUM`, `MAXV` and `NCNT` are valid.
- `OUT_READY` in 1: consumer takes the output.

## Operation
- FSM has two states: ACCUM and HOLD. Reset state is ACCUM.
- On reset:
  - `IN_READY`=1, `OUT_VALID`=0.
  - `SUM`=0, `MAXV`=0, `NCNT`=0.
  - Internal accumulator, max and count cleared.
- ACCUM:
  - `IN_READY`=1.
  - A sample is accepted when `IN_VALID`=1.
  - On accept: `acc += zero_extend(XOUT)`, computed modulo 2^`SUM_W`; `mx = max(mx, XOUT)`, unsigned compare; `cnt += 1`.
- A window closes in ACCUM when either of these holds:
  - a sample is accepted and the new count equals `NSAMPLES`;
  - `FLUSH`=1 and the post-accept count is greater than 0.
- On window close:
  - the final values including this cycle's sample load into `SUM`/`MAXV`/`NCNT`;
  - `OUT_VALID` goes to 1 and the FSM moves to HOLD;
  - the internal accumulator, max and count clear.
- `FLUSH` with an empty window and no accepted sample is ignored; no output is produced.
- HOLD:
  - `IN_READY`=0; `FLUSH` is ignored.
  - Outputs stay stable while `OUT_VALID`=1 and `OUT_READY`=0.
  - When `OUT_READY`=1: `OUT_VALID` drops to 0 the next cycle and the FSM returns to ACCUM.
  - `SUM`/`MAXV`/`NCNT` keep their last values after consumption.
- Arithmetic: overflow beyond `SUM_W` wraps silently. With the default parameters overflow cannot occur, since 4×255 = 1020.
- `IN_READY` is a function of state only and does not depend combinationally on `IN_VALID` or `OUT_READY`.

## Timing
- Latency: output valid 1 cycle after the edge that accepted the closing sample. There is no combinational path from input to output.
- Throughput:
  - one sample per cycle within a window;
  - each window costs at least 1 HOLD cycle;
  - `NSAMPLES`=4 with an always-ready consumer therefore gives 4 samples per 5 cycles.
- In HOLD with `OUT_READY`=1, `IN_READY` is 0 for that cycle and becomes 1 on the following cycle.
- Reset asserted mid-window or in HOLD:
  - immediate return to ACCUM with reset values;
  - the partial window is discarded;
  - a pending output is lost.
- Reset deassertion must meet recovery timing to `CLK`. The first sample can be accepted on the first edge after release.

## Structure
- Shared package `xout_accum_pkg` holds:
  - the state enum (`ACCUM`, `HOLD`);
  - the default constants `XACC_DATA_W`=8, `XACC_NSAMPLES`=4 and `XACC_SUM_W`=16.
- One sub-module, `xout_window_stats`, holds accumulator, max and count with `clear`/`accept` controls. The top level holds the FSM and the output registers.

## Test plan
- Full window, defaults: after reset, send 9, 4, 200, 7 back-to-back with `OUT_READY`=1 -> one cycle after the 4th accept, `SUM`=220, `MAXV`=200, `NCNT`=4, `OUT_VALID`=1 for 1 cycle; `IN_READY` is 0 during that cycle.
- Backpressure: same window with `OUT_READY`=0 for 6 cycles -> outputs stable and `IN_READY`=0 throughout; on `OUT_READY`=1, the next cycle has `OUT_VALID`=0 and `IN_READY`=1.
- Flush: send 10, 20, then 30 with `FLUSH`=1 in the same cycle -> `SUM`=60, `MAXV`=30, `NCNT`=3. A `FLUSH` pulse alone on an empty window -> no `OUT_VALID`.
- Wrap: `SUM_W`=8, `NSAMPLES`=2, samples 200, 100 -> `SUM`=44, `MAXV`=200.
- Reset mid-window: send 255, 255, assert `RST` asynchronously between edges, then send 1, 2, 3, 4 -> `SUM`=10, `NCNT`=4. `SUM` reads 0 while `RST` is asserted.
- Upstream chain: drive from the entity with A=3, B=5, so `XOUT`=10, for 4 samples -> `SUM`=40, `MAXV`=10.

Source files
------------

// File: rtl/xout_accum_pkg.sv
// xout_accum_pkg: shared state encoding and default sizing for the XOUT accumulator
package xout_accum_pkg;
  typedef enum logic {ACCUM, HOLD} state_t;
  localparam int XACC_DATA_W = 8;
  localparam int XACC_NSAMPLES = 4;
  localparam int XACC_SUM_W = 16;
endpackage

// File: rtl/xout_window_stats.sv
// xout_window_stats: running sum, max and count of one window, with post-accept lookahead
module xout_window_stats
  import xout_accum_pkg::*;
#(
  parameter int DATA_W = XACC_DATA_W,
  parameter int SUM_W = XACC_SUM_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              accept,
  input  logic [DATA_W-1:0] din,
  output logic [SUM_W-1:0]  acc_nxt,
  output logic [DATA_W-1:0] mx_nxt,
  output logic [7:0]        cnt_nxt
);
  logic [SUM_W-1:0] acc;
  logic [DATA_W-1:0] mx;
  logic [7:0] cnt;
  // lookahead values include this cycle's sample so a closing window is emitted complete
  always_comb begin
    acc_nxt = accept ? acc + SUM_W'(din) : acc;
    mx_nxt = accept && din > mx ? din : mx;
    cnt_nxt = accept ? cnt + 8'd1 : cnt;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      acc <= '0;
      mx <= '0;
      cnt <= '0;
    end else begin
      acc <= clear ? '0 : acc_nxt;
      mx <= clear ? '0 : mx_nxt;
      cnt <= clear ? '0 : cnt_nxt;
    end
endmodule

// File: rtl/xout_accum.sv
// xout_accum: windows the XOUT stream into sum/max/count results held until consumed
module xout_accum
  import xout_accum_pkg::*;
#(
  parameter int DATA_W = XACC_DATA_W,
  parameter int NSAMPLES = XACC_NSAMPLES,
  parameter int SUM_W = XACC_SUM_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] XOUT,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic              FLUSH,
  output logic [SUM_W-1:0]  SUM,
  output logic [DATA_W-1:0] MAXV,
  output logic [7:0]        NCNT,
  output logic              OUT_VALID,
  input  logic              OUT_READY
);
  state_t state, state_nxt;
  logic accept, close;
  logic [SUM_W-1:0] acc_nxt;
  logic [DATA_W-1:0] mx_nxt;
  logic [7:0] cnt_nxt;
  assign accept = state == ACCUM && IN_VALID;
  assign close = state == ACCUM &&
                 ((IN_VALID && cnt_nxt == 8'(NSAMPLES)) || (FLUSH && cnt_nxt != 8'd0));
  xout_window_stats #(.DATA_W(DATA_W), .SUM_W(SUM_W)) stats (
    .clk(CLK),
    .rst(RST),
    .clear(close),
    .accept(accept),
    .din(XOUT),
    .acc_nxt(acc_nxt),
    .mx_nxt(mx_nxt),
    .cnt_nxt(cnt_nxt)
  );
  always_ff @(posedge CLK or posedge RST)
    if (RST) state <= ACCUM;
    else state <= state_nxt;
  always_comb
    state_nxt = state == ACCUM ? (close ? HOLD : ACCUM) : (OUT_READY ? ACCUM : HOLD);
  always_comb begin
    IN_READY = state == ACCUM;
    OUT_VALID = state == HOLD;
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      SUM <= '0;
      MAXV <= '0;
      NCNT <= '0;
    end else if (close) begin
      SUM <= acc_nxt;
      MAXV <= mx_nxt;
      NCNT <= cnt_nxt;
    end
endmodule

// File: tb/tb_xout_accum.sv
// tb_xout_accum: directed and randomized checks of xout_accum against a window-list model
module tb_xout_accum;
  logic CLK = 0, RST = 1;
  logic [7:0] XOUT = 0;
  logic IN_VALID = 0, FLUSH = 0, OUT_READY = 0;
  logic IN_READY, OUT_VALID;
  logic [15:0] SUM;
  logic [7:0] MAXV, NCNT;
  logic [7:0] wx = 0;
  logic wv = 0, wir, wov;
  logic [7:0] wsum, wmax, wncnt;
  int checks = 0, errors = 0;
  int win[$];
  bit m_hold = 0;
  int m_sum = 0, m_max = 0, m_n = 0;

  always #5 CLK = ~CLK;

  xout_accum dut (
    .CLK(CLK), .RST(RST), .XOUT(XOUT), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .FLUSH(FLUSH), .SUM(SUM), .MAXV(MAXV), .NCNT(NCNT), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY)
  );

  xout_accum #(.DATA_W(8), .NSAMPLES(2), .SUM_W(8)) dutw (
    .CLK(CLK), .RST(RST), .XOUT(wx), .IN_VALID(wv), .IN_READY(wir),
    .FLUSH(1'b0), .SUM(wsum), .MAXV(wmax), .NCNT(wncnt), .OUT_VALID(wov),
    .OUT_READY(1'b1)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_in_ready"}, int'(IN_READY), int'(!m_hold));
    check({tag, "_out_valid"}, int'(OUT_VALID), int'(m_hold));
    check({tag, "_sum"}, int'(SUM), m_sum);
    check({tag, "_maxv"}, int'(MAXV), m_max);
    check({tag, "_ncnt"}, int'(NCNT), m_n);
  endtask

  // one clock: drive, let the edge happen, advance the model, compare
  task automatic step(input bit v, input int x, input bit f, input bit r, input string tag);
    IN_VALID = v;
    XOUT = 8'(x);
    FLUSH = f;
    OUT_READY = r;
    @(posedge CLK);
    if (!m_hold) begin
      if (v) win.push_back(x);
      if (win.size() == 4 || (f && win.size() > 0)) begin
        m_sum = 0;
        m_max = 0;
        foreach (win[i]) begin
          m_sum += win[i];
          if (win[i] > m_max) m_max = win[i];
        end
        m_sum = m_sum % 65536;
        m_n = win.size();
        win.delete();
        m_hold = 1;
      end
    end else if (r) m_hold = 0;
    #1;
    check_all(tag);
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    check_all("reset");
    RST = 0;
    step(0, 0, 0, 0, "idle");
    // full window with always-ready consumer
    step(1, 9, 0, 1, "full1");
    step(1, 4, 0, 1, "full2");
    step(1, 200, 0, 1, "full3");
    step(1, 7, 0, 1, "full4");
    check("full_sum", int'(SUM), 220);
    check("full_max", int'(MAXV), 200);
    check("full_ready_low", int'(IN_READY), 0);
    step(1, 99, 0, 1, "full_release");
    check("full_valid_drop", int'(OUT_VALID), 0);
    step(0, 0, 1, 1, "flush_after_release");
    // backpressure: sample 99 was dropped in HOLD, so the next window starts clean
    step(1, 9, 0, 0, "bp1");
    step(1, 4, 0, 0, "bp2");
    step(1, 200, 0, 0, "bp3");
    step(1, 7, 0, 0, "bp4");
    for (int i = 0; i < 6; i++) step(1, 55, 1, 0, "bp_hold");
    check("bp_stable_sum", int'(SUM), 220);
    step(1, 55, 0, 1, "bp_release");
    check("bp_after_valid", int'(OUT_VALID), 0);
    check("bp_after_ready", int'(IN_READY), 1);
    // flush partial window, then flush on an empty window
    step(1, 10, 0, 1, "fl1");
    step(1, 20, 0, 1, "fl2");
    step(1, 30, 1, 1, "fl3");
    check("flush_sum", int'(SUM), 60);
    check("flush_max", int'(MAXV), 30);
    check("flush_ncnt", int'(NCNT), 3);
    step(0, 0, 0, 1, "fl_release");
    step(0, 0, 1, 1, "fl_empty");
    check("flush_empty_valid", int'(OUT_VALID), 0);
    // wrap on the narrow instance
    wv = 1; wx = 200;
    step(0, 0, 0, 1, "wrap1");
    wx = 100;
    step(0, 0, 0, 1, "wrap2");
    wv = 0;
    check("wrap_sum", int'(wsum), 44);
    check("wrap_max", int'(wmax), 200);
    check("wrap_ncnt", int'(wncnt), 2);
    check("wrap_valid", int'(wov), 1);
    // async reset mid-window
    step(1, 255, 0, 1, "rm1");
    step(1, 255, 0, 1, "rm2");
    IN_VALID = 0;
    RST = 1;
    #2;
    win.delete();
    m_hold = 0; m_sum = 0; m_max = 0; m_n = 0;
    check_all("in_reset");
    RST = 0;
    #1;
    step(1, 1, 0, 1, "ra1");
    step(1, 2, 0, 1, "ra2");
    step(1, 3, 0, 1, "ra3");
    step(1, 4, 0, 1, "ra4");
    check("reset_sum", int'(SUM), 10);
    check("reset_ncnt", int'(NCNT), 4);
    step(0, 0, 0, 1, "ra_release");
    // upstream entity with A=3, B=5 yields XOUT=10
    for (int i = 0; i < 4; i++) step(1, 10, 0, 1, "chain");
    check("chain_sum", int'(SUM), 40);
    check("chain_max", int'(MAXV), 10);
    step(0, 0, 0, 1, "chain_release");
    // random traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(9, 0) < 7, int'($urandom_range(255, 0)),
           $urandom_range(9, 0) == 0, $urandom_range(9, 0) < 6, "rand");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
